// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared constants and types for the parking-lot sensor front end.
//   DEBOUNCE_CYCLES_DEF : default number of stable synchronized cycles per change
//   STUCK_CYCLES_DEF    : default high-time before a sensor is flagged stuck
//   sensor_status_t     : per-sensor status bundle (level, rise, stuck) consumed
//                         by the display/maintenance logic
// -----------------------------------------------------------------------------
package sensor_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int STUCK_CYCLES_DEF    = 1000;

    typedef struct packed {
        logic level;   // debounced sensor level
        logic rise;    // one-cycle pulse on level 0->1
        logic stuck;   // level held high for STUCK_CYCLES or more
    } sensor_status_t;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One sensor channel: 2-flop synchronizer, debouncer, rise pulse and
// stuck-high detector. Every output is a flop; nothing is combinational
// from raw_i.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   raw_i    : raw sensor line, asynchronous to clk_i
//   status_o : {level, rise, stuck}
// -----------------------------------------------------------------------------
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           raw_i,
    output sensor_status_t status_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(STUCK_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(STUCK_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX    = HW'(STUCK_CYCLES);

    logic          s1_q, s2_q;
    logic          f_q, f_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          stuck_q, stuck_d;

    // Debouncer: any disagreement between s2 and f that does not persist for
    // DEBOUNCE_CYCLES consecutive cycles restarts the count.
    always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        if (s2_q == f_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            f_d   = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign rise_d = f_d & ~f_q;

    // Stuck detector. Clearing keys off f_d so stuck drops on the same edge
    // the level falls; counting keys off f_q so hcnt equals the number of
    // cycles f has already been high, and stuck sets once that reaches
    // STUCK_CYCLES.
    always_comb begin
        hcnt_d  = hcnt_q;
        stuck_d = stuck_q;
        if (!f_d) begin
            hcnt_d  = '0;
            stuck_d = 1'b0;
        end else if (f_q) begin
            if (hcnt_q != H_MAX) hcnt_d = hcnt_q + 1'b1;
            if (hcnt_q == H_LAST) stuck_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            f_q     <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            hcnt_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            hcnt_q  <= hcnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign status_o.level = f_q;
    assign status_o.rise  = rise_q;
    assign status_o.stuck = stuck_q;

endmodule

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Front end for the occupancy counter: conditions the outer and inner
// photo-sensor lines through two independent, identical channels.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   outer_raw    : raw outer sensor (async)
//   inner_raw    : raw inner sensor (async)
//   outer/inner  : debounced levels to the counter
//   *_rise       : one-cycle pulse on level 0->1
//   *_stuck      : level held high >= STUCK_CYCLES
// -----------------------------------------------------------------------------
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic outer_raw,
    input  logic inner_raw,
    output logic outer,
    output logic inner,
    output logic outer_rise,
    output logic inner_rise,
    output logic outer_stuck,
    output logic inner_stuck
);

    sensor_status_t outer_st, inner_st;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_outer (
        .clk_i    (clk),
        .rst_ni   (reset),
        .raw_i    (outer_raw),
        .status_o (outer_st)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_inner (
        .clk_i    (clk),
        .rst_ni   (reset),
        .raw_i    (inner_raw),
        .status_o (inner_st)
    );

    assign outer       = outer_st.level;
    assign outer_rise  = outer_st.rise;
    assign outer_stuck = outer_st.stuck;
    assign inner       = inner_st.level;
    assign inner_rise  = inner_st.rise;
    assign inner_stuck = inner_st.stuck;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Output vector order: {outer, inner, outer_rise, inner_rise, outer_stuck, inner_stuck}
// Expectations are tagged with the edge count after which they must hold.
module tb_sensor_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic outer_raw = 1'b0;
    logic inner_raw = 1'b0;
    logic outer, inner, outer_rise, inner_rise, outer_stuck, inner_stuck;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .outer_raw   (outer_raw),
        .inner_raw   (inner_raw),
        .outer       (outer),
        .inner       (inner),
        .outer_rise  (outer_rise),
        .inner_rise  (inner_rise),
        .outer_stuck (outer_stuck),
        .inner_stuck (inner_stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Called at a negedge: expectation holds right after edge (cyc + off).
    task automatic expect_at(input int off, input logic [5:0] v, input string nm);
        exp_t e;
        e.at   = cyc + off;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: one tick after each active edge, retire every expectation due now.
    initial begin : monitor
        logic [5:0] act;
        forever begin
            @(posedge clk);
            #1;
            act = {outer, inner, outer_rise, inner_rise, outer_stuck, inner_stuck};
            for (int i = 0; i < sb.size(); ) begin
                if (sb[i].at == cyc) begin
                    checks++;
                    if (act !== sb[i].val) begin
                        errors++;
                        $display("FAIL %s @edge%0d: got %b expected %b", sb[i].name, cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end else if (sb[i].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for edge %0d never checked", sb[i].name, sb[i].at);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin : stim
        // Reset held, raws toggling: everything stays cleared.
        step(1);
        for (int k = 0; k < 4; k++) begin
            outer_raw = k[0];
            inner_raw = ~k[0];
            expect_at(1, 6'b000000, "reset_hold");
            step(1);
        end
        outer_raw = 1'b0;
        inner_raw = 1'b0;
        reset = 1'b1;
        expect_at(1, 6'b000000, "reset_rel1");
        expect_at(6, 6'b000000, "reset_rel6");
        step(8);

        // Clean entry: outer, then inner, then release both.
        outer_raw = 1'b1;
        expect_at(5, 6'b000000, "outer_pre");
        expect_at(6, 6'b101000, "outer_rise");
        expect_at(7, 6'b100000, "outer_rise_1cyc");
        step(8);
        inner_raw = 1'b1;
        expect_at(5, 6'b100000, "inner_pre");
        expect_at(6, 6'b110100, "inner_rise");
        expect_at(7, 6'b110000, "inner_rise_1cyc");
        step(8);
        outer_raw = 1'b0;
        inner_raw = 1'b0;
        expect_at(5, 6'b110000, "fall_pre");
        expect_at(6, 6'b000000, "fall_both");
        expect_at(7, 6'b000000, "fall_no_pulse");
        step(10);

        // Glitch of 3 cycles is rejected.
        outer_raw = 1'b1;
        step(3);
        outer_raw = 1'b0;
        for (int k = 2; k <= 6; k++) expect_at(k, 6'b000000, "glitch3");
        step(10);

        // 4-cycle pulse passes through and returns low.
        outer_raw = 1'b1;
        expect_at(5, 6'b000000, "pulse4_pre");
        expect_at(6, 6'b101000, "pulse4_rise");
        expect_at(7, 6'b100000, "pulse4_high");
        step(4);
        outer_raw = 1'b0;
        expect_at(5, 6'b100000, "pulse4_fall_pre");
        expect_at(6, 6'b000000, "pulse4_fall");
        step(10);

        // Simultaneous rise; then outer drops, inner held until stuck.
        outer_raw = 1'b1;
        inner_raw = 1'b1;
        expect_at(5, 6'b000000, "sim_pre");
        expect_at(6, 6'b111100, "sim_rise");
        expect_at(7, 6'b110000, "sim_high");
        step(8);
        outer_raw = 1'b0;
        // inner rose at (this cyc - 2); stuck 16 edges later = this cyc + 14
        expect_at(6, 6'b010000, "outer_dropped");
        expect_at(13, 6'b010000, "stuck_pre");
        expect_at(14, 6'b010001, "stuck_set");
        expect_at(22, 6'b010001, "stuck_hold");
        step(23);
        inner_raw = 1'b0;
        expect_at(5, 6'b010001, "stuck_until_fall");
        expect_at(6, 6'b000000, "stuck_clear");
        step(10);

        // Reset in the middle of a debounce count.
        outer_raw = 1'b1;
        step(2);
        reset = 1'b0;
        expect_at(1, 6'b000000, "mid_rst_hold");
        step(2);
        reset = 1'b1;
        expect_at(1, 6'b000000, "mid_rst_rel");
        expect_at(5, 6'b000000, "mid_rst_pre");
        expect_at(6, 6'b101000, "mid_rst_rise");
        step(10);
        outer_raw = 1'b0;
        step(10);

        stim_done = 1'b1;
        step(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: timeout at edge %0d, expected finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front end for the parking-lot occupancy counter.
- Takes the two raw, asynchronous photo-sensor lines (outer, inner) and synchronizes and debounces each one.
- Produces clean, single-clock-domain `outer`/`inner` levels that drive the occupancy counter's sensor inputs directly.
- Also provides one-cycle rising-edge pulses and a per-sensor "stuck blocked" status flag for the display/maintenance logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a filtered output changes (legal range 1..255).
- STUCK_CYCLES, 1000, consecutive cycles a filtered output may stay high before its stuck flag asserts (legal range 2..65535).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- outer_raw  input  1  raw outer sensor, asynchronous to clk
- inner_raw  input  1  raw inner sensor, asynchronous to clk
- outer  output  1  debounced outer level (to counter)
- inner  output  1  debounced inner level (to counter)
- outer_rise  output  1  one-cycle pulse on outer 0->1
- inner_rise  output  1  one-cycle pulse on inner 0->1
- outer_stuck  output  1  outer held high >= STUCK_CYCLES
- inner_stuck  output  1  inner held high >= STUCK_CYCLES

Behaviour:
- Reset:
  - While reset=0, all flops clear asynchronously: sync stages, counters, outer, inner, *_rise, *_stuck are all 0.
  - Release is synchronous to the next clk edge and needs no special sequencing.
- Channels are fully independent. Simultaneous changes on both raw inputs are processed in parallel with identical latency.
- Synchronizer: two flops per channel (s1, s2). s2 is the only signal the debouncer sees.
- Debouncer, per channel:
  - State is the filtered output `f` plus counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge:
    - if s2 == f: cnt <= 0.
    - else if cnt == DEBOUNCE_CYCLES-1: f <= s2, cnt <= 0.
    - else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles restarts the count and never reaches f.
- Latency:
  - Raw change set up before edge 0 and held: f changes at edge DEBOUNCE_CYCLES+1.
  - With DEBOUNCE_CYCLES=1 the block degenerates to a pure 2-flop synchronizer (latency 2).
- Rise pulse: *_rise is registered and high for exactly the one cycle after the edge where f goes 0->1. There is no fall pulse.
- Stuck detector, per channel:
  - Counter `hcnt`, width $clog2(STUCK_CYCLES+1), saturating.
  - f == 0: hcnt <= 0, stuck <= 0.
  - f == 1: hcnt increments, saturating at STUCK_CYCLES. stuck asserts on the edge where hcnt reaches STUCK_CYCLES-1 and f is still 1, i.e. stuck is high after STUCK_CYCLES consecutive cycles of f=1.
  - stuck stays high while f=1 and clears on the same edge f falls to 0.
  - stuck never alters f; the counter still sees the level.
- Reset mid-debounce: pending counts are discarded. After release, a still-changed raw input needs the full DEBOUNCE_CYCLES+1 edges again.
- No combinational path from any input to any output.

Decomposition:
- Package `sensor_pkg`:
  - default constants DEBOUNCE_CYCLES_DEF=4 and STUCK_CYCLES_DEF=1000
  - typedef `sensor_status_t` (struct: level, rise, stuck) used by downstream display logic
- One sub-module, `debounce_channel` (synchronizer + debouncer + rise + stuck for one sensor), instantiated twice in sensor_conditioner.
- Estimated RTL: ~150 lines sub-module, ~60 lines top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, STUCK_CYCLES=16 and check on posedge clk.
- Reset: hold reset=0 with raw inputs toggling -> all six outputs 0. Release with raws at 0 -> outputs remain 0.
- Clean entry sequence:
  - outer_raw=1 held -> outer=1 after edge 5 and outer_rise high for exactly one cycle.
  - Then inner_raw=1 -> inner=1 five edges later.
  - Release both -> each falls five edges after its raw, with no rise pulses.
- Glitch rejection: outer_raw high for 3 cycles then low -> outer stays 0, outer_rise never pulses. A 4-cycle pulse -> outer goes high then returns low.
- Simultaneous change: both raws 0->1 on the same cycle -> outer and inner rise on the same edge (edge 5), with both rise pulses in the same cycle.
- Stuck: inner_raw held 1 -> inner_stuck=1 exactly 16 cycles after inner rises and stays 1. Drop inner_raw -> inner_stuck clears on the edge inner falls.
- Reset mid-debounce: outer_raw 0->1, assert reset after 2 edges, release -> outer=0 immediately; outer=1 only 5 edges after release.
